// File: rtl/dna_pkg.sv
// Shared nucleotide types, rank helper and orientation enum for the DNA
// orientation pipeline.
package dna_pkg;

  typedef logic [1:0] nuc_t;

  localparam nuc_t NUC_1 = 2'b01;
  localparam nuc_t NUC_2 = 2'b10;
  localparam nuc_t NUC_3 = 2'b11;
  localparam nuc_t NUC_4 = 2'b00;

  typedef enum logic [1:0] {
    OR_FWD = 2'd0,
    OR_REV = 2'd1,
    OR_PFX = 2'd2
  } orient_e;

  // Rank order used for classification: 01 < 10 < 11 < 00.
  function automatic logic [2:0] nuc_rank(input nuc_t d);
    logic [2:0] r;
    case (d)
      NUC_1:   r = 3'd1;
      NUC_2:   r = 3'd2;
      NUC_3:   r = 3'd3;
      default: r = 3'd4;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dna_prefix_classify.sv
// Combinational orientation classifier from the two leading digits of a word.
module dna_prefix_classify
  import dna_pkg::*;
(
  input  nuc_t    d0,
  input  nuc_t    d1,
  output orient_e orient
);

  logic [2:0] w_r0;
  logic [2:0] w_r1;

  assign w_r0 = nuc_rank(d0);
  assign w_r1 = nuc_rank(d1);

  // Ascending leading ranks mean forward, descending mean reversed, equal
  // ranks mean the deletion sits in the prefix.
  always_comb begin
    orient = OR_PFX;
    if (w_r0 < w_r1)      orient = OR_FWD;
    else if (w_r0 > w_r1) orient = OR_REV;
  end

endmodule

// File: rtl/dna_orient_pipe.sv
// Two-stage valid/ready orientation stage for DNA codewords.
// S1 captures the word and its classification, S2 holds the word in forward
// orientation together with its flags.
// Optional statistics counters are built when DNA_ORIENT_STATS_EN is defined;
// otherwise rev_count/pfx_count read 0 and stats_clr is ignored.
module dna_orient_pipe
  import dna_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_word,
  output logic             out_reversed,
  output logic             out_in_prefix,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] rev_count,
  output logic [CNT_W-1:0] pfx_count
);

  orient_e        w_orient;
  logic           w_adv1;
  logic           w_adv2;
  logic [2*N-1:0] w_rev_word;
  logic [2*N-1:0] w_fwd_word;

  logic           r_s1_v;
  logic [2*N-1:0] r_s1_word;
  logic           r_s1_rev;
  logic           r_s1_pfx;

  logic           r_s2_v;
  logic [2*N-1:0] r_s2_word;
  logic           r_s2_rev;
  logic           r_s2_pfx;

  dna_prefix_classify u_classify (
    .d0     (in_word[2*N-1 -: 2]),
    .d1     (in_word[2*N-3 -: 2]),
    .orient (w_orient)
  );

  assign w_adv2   = !r_s2_v || out_ready;
  assign w_adv1   = !r_s1_v || w_adv2;
  assign in_ready = w_adv1;

  // Digit i of the result takes digit N-1-i of the S1 word; the mapping is
  // symmetric on the 2-bit lane index, bits inside a digit keep their order.
  for (genvar gi = 0; gi < N; gi++) begin : g_rev
    assign w_rev_word[2*gi +: 2] = r_s1_word[2*(N-1-gi) +: 2];
  end

  assign w_fwd_word = r_s1_rev ? w_rev_word : r_s1_word;

  // Stage 1: capture the incoming word and its classification.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v    <= 1'b0;
      r_s1_word <= '0;
      r_s1_rev  <= 1'b0;
      r_s1_pfx  <= 1'b0;
    end else if (w_adv1) begin
      r_s1_v <= in_valid;
      if (in_valid) begin
        r_s1_word <= in_word;
        r_s1_rev  <= (w_orient == OR_REV);
        r_s1_pfx  <= (w_orient == OR_PFX);
      end
    end
  end

  // Stage 2: hold the forward-oriented word and flags for the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_v    <= 1'b0;
      r_s2_word <= '0;
      r_s2_rev  <= 1'b0;
      r_s2_pfx  <= 1'b0;
    end else if (w_adv2) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_word <= w_fwd_word;
        r_s2_rev  <= r_s1_rev;
        r_s2_pfx  <= r_s1_pfx;
      end
    end
  end

  assign out_valid     = r_s2_v;
  assign out_word      = r_s2_word;
  assign out_reversed  = r_s2_rev;
  assign out_in_prefix = r_s2_pfx;

`ifdef DNA_ORIENT_STATS_EN
  localparam logic [CNT_W-1:0] L_ONE = CNT_W'(1);

  logic             w_out_hs;
  logic [CNT_W-1:0] r_rev_cnt;
  logic [CNT_W-1:0] r_pfx_cnt;

  assign w_out_hs = r_s2_v && out_ready;

  // Saturating emit counters; a clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rev_cnt <= '0;
      r_pfx_cnt <= '0;
    end else if (stats_clr) begin
      r_rev_cnt <= '0;
      r_pfx_cnt <= '0;
    end else if (w_out_hs) begin
      if (r_s2_rev && (r_rev_cnt != '1)) r_rev_cnt <= r_rev_cnt + L_ONE;
      if (r_s2_pfx && (r_pfx_cnt != '1)) r_pfx_cnt <= r_pfx_cnt + L_ONE;
    end
  end

  assign rev_count = r_rev_cnt;
  assign pfx_count = r_pfx_cnt;
`else
  logic w_unused_clr;

  assign w_unused_clr = stats_clr;
  assign rev_count    = '0;
  assign pfx_count    = '0;
`endif

endmodule
